// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: in-order requests to a variable-latency imem,
// a prefetch queue of {instr, pc}, and beq/bne redirect with stale-response dropping.
module fetch_prefetch_queue #(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter int                QDEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               br_valid,
  input  logic [ADDR_W-1:0]  br_pc,
  input  logic [ADDR_W-1:0]  br_imm,
  input  logic               beq,
  input  logic               bne,
  input  logic               zero_flag,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [INSTR_W-1:0] q_instr [QDEPTH];
  logic [ADDR_W-1:0]  q_pc    [QDEPTH];
  logic [PW-1:0]      rd_ptr, wr_ptr;
  logic [CW-1:0]      count, outstanding, drop, out_next;
  logic [CW:0]        credit;
  logic [ADDR_W-1:0]  fetch_pc, resp_pc, target;
  logic               taken, hs, rsp, discard, push, pop;

  // Credit covers queued entries plus every in-flight request, so a response
  // always has a slot waiting for it.
  assign credit         = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = ~rst & (credit < (CW+1)'(QDEPTH));
  assign imem_req_addr  = fetch_pc;

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? q_instr[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? q_pc[rd_ptr]    : '0;

  assign taken  = br_valid & ((beq & zero_flag) | (bne & ~zero_flag));
  assign target = (br_pc + (br_imm << 2)) & ~(ADDR_W'(3));

  assign hs       = imem_req_valid & imem_req_ready;
  assign rsp      = imem_rsp_valid & (outstanding != '0);
  assign discard  = rsp & ((drop != '0) | taken);
  assign push     = rsp & ~discard;
  assign pop      = instr_valid & instr_ready;
  assign out_next = outstanding + CW'(hs) - CW'(rsp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= out_next;
      if (taken) begin
        // Everything still in flight belongs to the old stream, including a
        // request accepted this very cycle.
        fetch_pc <= target;
        resp_pc  <= target;
        drop     <= out_next;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (hs) fetch_pc <= fetch_pc + ADDR_W'(4);
        if (push) begin
          resp_pc <= resp_pc + ADDR_W'(4);
          wr_ptr  <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        if (rsp && (drop != '0)) drop <= drop - CW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= imem_rsp_data;
      q_pc[wr_ptr]    <= resp_pc;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count == CW'(QDEPTH))));

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomized bench for fetch_prefetch_queue: a queue-based memory/stream model
// predicts every output each cycle, plus directed redirect and reset scenarios.
module tb_fetch_prefetch_queue;
  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;
  localparam int QDEPTH  = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               imem_req_valid;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_req_ready = 1'b0;
  logic               imem_rsp_valid = 1'b0;
  logic [INSTR_W-1:0] imem_rsp_data  = '0;
  logic               br_valid = 1'b0;
  logic [ADDR_W-1:0]  br_pc    = '0;
  logic [ADDR_W-1:0]  br_imm   = '0;
  logic               beq = 1'b0, bne = 1'b0, zero_flag = 1'b0;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready = 1'b0;

  fetch_prefetch_queue #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .QDEPTH(QDEPTH), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .br_valid(br_valid), .br_pc(br_pc), .br_imm(br_imm), .beq(beq), .bne(bne), .zero_flag(zero_flag),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] addr; int due; bit stale; } req_t;
  typedef struct { logic [31:0] data; logic [63:0] pc; } ent_t;

  req_t        pend[$];   // accepted, not yet answered (memory + model)
  ent_t        mq[$];     // instructions decode should see, in order
  logic [63:0] m_fetch_pc;
  int          cyc, last_due;
  int          lat_min, lat_max, ready_pct, irdy_pct, br_pct;
  bit          spurious;
  bit          force_br;
  logic [63:0] f_pc, f_imm;
  logic        f_beq, f_bne, f_z;
  int          checks, errors;
  int          hs_cnt, pop_cnt, first_hs, first_iv;
  bit          pop_flag;
  logic [63:0] pop_pc;

  function automatic logic [31:0] hash(logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    bit          exp_rv, exp_iv, hs, pop, tk;
    int          lat;
    req_t        r;
    ent_t        e;
    logic [7:0]  s;
    @(posedge clk); #1;
    cyc++;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = hash(pend[0].addr);
    end else if (pend.size() == 0 && spurious && $urandom_range(0, 7) == 0) begin
      imem_rsp_valid = 1'b1;
    end
    imem_req_ready = ($urandom_range(0, 99) < ready_pct);
    instr_ready    = ($urandom_range(0, 99) < irdy_pct);
    if (force_br) begin
      br_valid = 1'b1; br_pc = f_pc; br_imm = f_imm; beq = f_beq; bne = f_bne; zero_flag = f_z;
    end else begin
      s         = 8'($urandom);
      br_valid  = ($urandom_range(0, 99) < br_pct);
      br_pc     = {48'h0, 16'($urandom)};
      br_imm    = {{56{s[7]}}, s};
      beq       = 1'($urandom);
      bne       = 1'($urandom);
      zero_flag = 1'($urandom);
    end
    @(negedge clk);
    exp_rv = (mq.size() + pend.size()) < QDEPTH;
    exp_iv = (mq.size() > 0);
    chk("req_valid", 64'(imem_req_valid), 64'(exp_rv));
    chk("req_addr", imem_req_addr, m_fetch_pc);
    chk("instr_valid", 64'(instr_valid), 64'(exp_iv));
    if (exp_iv) begin
      chk("instr", 64'(instr), 64'(mq[0].data));
      chk("instr_pc", instr_pc, mq[0].pc);
    end
    if (imem_req_valid && imem_req_ready) begin
      hs_cnt++;
      if (first_hs < 0) first_hs = cyc;
    end
    if (instr_valid && first_iv < 0) first_iv = cyc;
    if (instr_valid && instr_ready) begin
      pop_cnt++; pop_flag = 1'b1; pop_pc = instr_pc;
    end
    hs  = exp_rv && imem_req_ready;
    pop = exp_iv && instr_ready;
    tk  = br_valid && ((beq && zero_flag) || (bne && !zero_flag));
    if (pop) void'(mq.pop_front());
    if (imem_rsp_valid && pend.size() > 0) begin
      r = pend.pop_front();
      if (!r.stale && !tk) begin
        e.data = hash(r.addr); e.pc = r.addr;
        mq.push_back(e);
      end
    end
    if (hs) begin
      lat     = $urandom_range(lat_min, lat_max);
      r.addr  = m_fetch_pc;
      r.due   = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      r.stale = tk;
      last_due = r.due;
      pend.push_back(r);
      m_fetch_pc = m_fetch_pc + 64'd4;
    end
    if (tk) begin
      for (int i = 0; i < pend.size(); i++) pend[i].stale = 1'b1;
      mq.delete();
      m_fetch_pc = (br_pc + (br_imm << 2)) & ~64'h3;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b0; instr_ready = 1'b0; br_valid = 1'b0;
    #1;
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_req_addr", imem_req_addr, 64'd0);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_instr_pc", instr_pc, 64'd0);
    pend.delete(); mq.delete();
    m_fetch_pc = '0; last_due = 0;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic redirect_check(string tag, logic [63:0] pc, logic [63:0] imm,
                                logic b_eq, logic b_ne, logic z, logic [63:0] exp_pc);
    int n;
    f_pc = pc; f_imm = imm; f_beq = b_eq; f_bne = b_ne; f_z = z;
    force_br = 1'b1;
    step();
    force_br = 1'b0;
    pop_flag = 1'b0;
    step();
    chk({tag, "_flushed"}, 64'(instr_valid), 64'd0);
    n = 0;
    while (!pop_flag && n < 60) begin
      step();
      n++;
    end
    chk({tag, "_pop_seen"}, 64'(pop_flag), 64'd1);
    if (pop_flag) chk({tag, "_target"}, pop_pc, exp_pc);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; last_due = 0; m_fetch_pc = '0;
    force_br = 1'b0; spurious = 1'b0;
    lat_min = 1; lat_max = 1; ready_pct = 100; irdy_pct = 100; br_pct = 0;
    hs_cnt = 0; pop_cnt = 0; first_hs = -1; first_iv = -1; pop_flag = 1'b0; pop_pc = '0;

    do_reset();
    repeat (8) step();
    chk("first_latency", 64'(first_iv - first_hs), 64'd2);
    pop_cnt = 0;
    repeat (10) step();
    chk("throughput", 64'(pop_cnt), 64'd10);
    // redirect while a response and a handshake happen in the same cycle
    redirect_check("beq_neg_imm", 64'h40, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 1'b1, 64'h30);
    redirect_check("bne_misalign", 64'h43, 64'h1, 1'b0, 1'b1, 1'b0, 64'h44);

    do_reset();
    irdy_pct = 0; hs_cnt = 0;
    repeat (10) step();
    chk("stall_reqs", 64'(hs_cnt), 64'(QDEPTH));
    irdy_pct = 100;
    repeat (12) step();

    do_reset();
    lat_min = 3; lat_max = 3;
    repeat (3) step();
    redirect_check("beq_lat3", 64'h10, 64'h5, 1'b1, 1'b0, 1'b1, 64'h24);
    f_pc = 64'h80; f_imm = 64'h8; f_beq = 1'b0; f_bne = 1'b1; f_z = 1'b1;
    force_br = 1'b1; step(); force_br = 1'b0;
    f_beq = 1'b1; f_bne = 1'b0; f_z = 1'b0;
    force_br = 1'b1; step(); force_br = 1'b0;
    repeat (10) step();

    lat_min = 1; lat_max = 1; irdy_pct = 0;
    repeat (8) step();
    chk("full_before_reset", 64'(instr_valid), 64'd1);
    do_reset();
    irdy_pct = 100;
    repeat (10) step();

    lat_min = 1; lat_max = 4; ready_pct = 70; irdy_pct = 60; br_pct = 6; spurious = 1'b1;
    repeat (1500) step();
    do_reset();
    repeat (1500) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
